// File: rtl/coin_pulse_gen.sv
// Coin-sensor front end: per-channel 2-flop sync, debounce FSM and press-pulse generation.
// Define COIN_PULSE_ARB_EN to serialise simultaneous pulses (half first, one a cycle later).
module coin_pulse_gen #(
  parameter int unsigned CNT_MAX = 999_999
) (
  input  logic       i_sysclk,
  input  logic       i_sysrst_n,
  input  logic       i_key_one,
  input  logic       i_key_half,
  output logic       o_money_one,
  output logic       o_money_half,
  output logic [1:0] o_key_state
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam int unsigned CH_ONE  = 1;
  localparam int unsigned CH_HALF = 0;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_PRESS   = 4'b0010,
    ST_DOWN    = 4'b0100,
    ST_RELEASE = 4'b1000
  } state_e;

  logic [NCH-1:0]   key_raw;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   key_s_q;
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   press_c;
  logic [NCH-1:0]   key_state_q;
  logic [NCH-1:0]   key_state_d;
  logic             money_one_q;
  logic             money_one_d;
  logic             money_half_q;
  logic             money_half_d;

  assign key_raw = {i_key_one, i_key_half};

  // Synchronisers idle high so reset never looks like a press
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      sync1_q <= '1;
      key_s_q <= '1;
    end else begin
      sync1_q <= key_raw;
      key_s_q <= sync1_q;
    end
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= ST_IDLE;
        cnt_q[ch]   <= '0;
      end
      key_state_q  <= '0;
      money_one_q  <= 1'b0;
      money_half_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      key_state_q  <= key_state_d;
      money_one_q  <= money_one_d;
      money_half_q <= money_half_d;
    end
  end

  // Debounce FSM; counter is cleared on every state entry so it never wraps
  always_comb begin
    press_c     = '0;
    key_state_d = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        ST_IDLE: begin
          if (!key_s_q[ch]) begin
            state_d[ch] = ST_PRESS;
            cnt_d[ch]   = '0;
          end
        end
        ST_PRESS: begin
          if (key_s_q[ch]) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_W'(CNT_MAX - 1)) begin
            state_d[ch] = ST_DOWN;
            cnt_d[ch]   = '0;
            press_c[ch] = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (key_s_q[ch]) begin
            state_d[ch] = ST_RELEASE;
            cnt_d[ch]   = '0;
          end
        end
        ST_RELEASE: begin
          if (!key_s_q[ch]) begin
            state_d[ch] = ST_DOWN;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_W'(CNT_MAX - 1)) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        default: begin
          state_d[ch] = ST_IDLE;
          cnt_d[ch]   = '0;
        end
      endcase
      key_state_d[ch] = (state_d[ch] == ST_DOWN) || (state_d[ch] == ST_RELEASE);
    end
  end

`ifdef COIN_PULSE_ARB_EN
  logic pend_q;
  logic pend_d;

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Half wins a tie; a deferred one-yuan event owns the following cycle
  always_comb begin
    money_one_d  = pend_q | (press_c[CH_ONE] & ~press_c[CH_HALF]);
    money_half_d = press_c[CH_HALF] & ~pend_q;
    pend_d       = press_c[CH_ONE] & press_c[CH_HALF];
  end
`else
  always_comb begin
    money_one_d  = press_c[CH_ONE];
    money_half_d = press_c[CH_HALF];
  end
`endif

  assign o_money_one  = money_one_q;
  assign o_money_half = money_half_q;
  assign o_key_state  = key_state_q;

endmodule
